// File: rtl/calc_input_controller_if.sv
// Token, ALU request and ALU result signals between button_reader, the
// calculator input controller and the ALU.
interface calc_input_controller_if #(
  parameter int BITS = 16
);
  logic [4:0]      i_data;
  logic            i_valid;
  logic            o_ready;
  logic [BITS-1:0] o_alu_a;
  logic [BITS-1:0] o_alu_b;
  logic [1:0]      o_alu_op;
  logic            o_alu_valid;
  logic            i_alu_ready;
  logic [BITS-1:0] i_res_data;
  logic            i_res_err;
  logic            i_res_valid;
  logic [BITS-1:0] o_display;
  logic            o_error;

  modport slave (
    input  i_data, i_valid, i_alu_ready, i_res_data, i_res_err, i_res_valid,
    output o_ready, o_alu_a, o_alu_b, o_alu_op, o_alu_valid, o_display, o_error
  );

  modport master (
    output i_data, i_valid, i_alu_ready, i_res_data, i_res_err, i_res_valid,
    input  o_ready, o_alu_a, o_alu_b, o_alu_op, o_alu_valid, o_display, o_error
  );
endinterface

// File: rtl/calc_input_controller.sv
// Calculator input controller: builds decimal operands from key tokens, issues
// A op B to the ALU, and drives the display value and error flag.
module calc_input_controller #(
  parameter int BITS = 16
) (
  input logic                   clk,
  input logic                   rst,
  calc_input_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_ENTER_A, S_OP_WAIT, S_ENTER_B, S_ISSUE, S_WAIT_RES, S_SHOW_RES, S_ERROR
  } state_t;

  localparam logic [BITS+3:0] MAXV = {5'b0, {(BITS-1){1'b1}}};

  state_t          r_state, w_state_nxt;
  logic [BITS-1:0] r_a, w_a_nxt;
  logic [BITS-1:0] r_b, w_b_nxt;
  logic [1:0]      r_op, w_op_nxt;
  logic [1:0]      r_next_op, w_next_op_nxt;
  logic            r_pending, w_pending_nxt;
  logic            r_error, w_error_nxt;
  logic            r_ready, w_ready_nxt;
  logic            r_alu_valid, w_alu_valid_nxt;
  logic [BITS-1:0] r_display, w_display_nxt;

  logic       w_accept, w_is_digit, w_is_ac, w_is_op, w_is_eq;
  logic [3:0] w_digit;
  logic [1:0] w_tok_op;

  assign w_accept   = bus.i_valid & r_ready;
  assign w_is_digit = w_accept && (bus.i_data <= 5'd9);
  assign w_is_ac    = w_accept && (bus.i_data == 5'd10);
  assign w_is_op    = w_accept && (bus.i_data >= 5'd11) && (bus.i_data <= 5'd14);
  assign w_is_eq    = w_accept && (bus.i_data == 5'd15);
  assign w_digit    = bus.i_data[3:0];
  // Tokens 11..14 have low bits 3,0,1,2, so adding one yields ADD,SUB,MUL,DIV.
  assign w_tok_op   = bus.i_data[1:0] + 2'd1;

  function automatic logic [BITS-1:0] acc_digit(input logic [BITS-1:0] x,
                                                input logic [3:0]      d);
    logic [BITS+3:0] v;
    v = {4'b0, x} * (BITS+4)'(10) + {{BITS{1'b0}}, d};
    return (v <= MAXV) ? v[BITS-1:0] : x;
  endfunction

  always_comb begin
    // NOTE: every next-state value is defaulted to its current value first so
    // no branch can leave one unassigned and infer a latch.
    w_state_nxt   = r_state;
    w_a_nxt       = r_a;
    w_b_nxt       = r_b;
    w_op_nxt      = r_op;
    w_next_op_nxt = r_next_op;
    w_pending_nxt = r_pending;
    w_error_nxt   = r_error;

    if (w_is_ac) begin
      w_state_nxt   = S_ENTER_A;
      w_a_nxt       = '0;
      w_b_nxt       = '0;
      w_op_nxt      = 2'd0;
      w_pending_nxt = 1'b0;
      w_error_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_ENTER_A: begin
          if (w_is_digit) begin
            w_a_nxt = acc_digit(r_a, w_digit);
          end else if (w_is_op) begin
            w_op_nxt    = w_tok_op;
            w_state_nxt = S_OP_WAIT;
          end
        end
        S_OP_WAIT: begin
          if (w_is_op) begin
            w_op_nxt = w_tok_op;
          end else if (w_is_digit) begin
            w_b_nxt     = BITS'(w_digit);
            w_state_nxt = S_ENTER_B;
          end
        end
        S_ENTER_B: begin
          if (w_is_digit) begin
            w_b_nxt = acc_digit(r_b, w_digit);
          end else if (w_is_eq) begin
            w_pending_nxt = 1'b0;
            w_state_nxt   = S_ISSUE;
          end else if (w_is_op) begin
            w_next_op_nxt = w_tok_op;
            w_pending_nxt = 1'b1;
            w_state_nxt   = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_alu_valid && bus.i_alu_ready) w_state_nxt = S_WAIT_RES;
        end
        S_WAIT_RES: begin
          if (bus.i_res_valid) begin
            if (bus.i_res_err) begin
              w_error_nxt = 1'b1;
              w_state_nxt = S_ERROR;
            end else begin
              w_a_nxt = bus.i_res_data;
              w_b_nxt = '0;
              if (r_pending) begin
                w_op_nxt      = r_next_op;
                w_pending_nxt = 1'b0;
                w_state_nxt   = S_OP_WAIT;
              end else begin
                w_state_nxt = S_SHOW_RES;
              end
            end
          end
        end
        S_SHOW_RES: begin
          if (w_is_digit) begin
            w_a_nxt     = BITS'(w_digit);
            w_state_nxt = S_ENTER_A;
          end else if (w_is_op) begin
            w_op_nxt    = w_tok_op;
            w_state_nxt = S_OP_WAIT;
          end
        end
        S_ERROR: ;
        default: w_state_nxt = S_ENTER_A;
      endcase
    end

    // Registered outputs are derived from the next state so they line up with it.
    w_ready_nxt     = !(w_state_nxt == S_ISSUE || w_state_nxt == S_WAIT_RES);
    w_alu_valid_nxt = (w_state_nxt == S_ISSUE);
    case (w_state_nxt)
      S_ENTER_B, S_ISSUE, S_WAIT_RES: w_display_nxt = w_b_nxt;
      S_ERROR:                        w_display_nxt = '0;
      default:                        w_display_nxt = w_a_nxt;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_ENTER_A;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= 2'd0;
      r_next_op   <= 2'd0;
      r_pending   <= 1'b0;
      r_error     <= 1'b0;
      r_ready     <= 1'b1;
      r_alu_valid <= 1'b0;
      r_display   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_op        <= w_op_nxt;
      r_next_op   <= w_next_op_nxt;
      r_pending   <= w_pending_nxt;
      r_error     <= w_error_nxt;
      r_ready     <= w_ready_nxt;
      r_alu_valid <= w_alu_valid_nxt;
      r_display   <= w_display_nxt;
    end
  end

  assign bus.o_ready     = r_ready;
  assign bus.o_alu_a     = r_a;
  assign bus.o_alu_b     = r_b;
  assign bus.o_alu_op    = r_op;
  assign bus.o_alu_valid = r_alu_valid;
  assign bus.o_display   = r_display;
  assign bus.o_error     = r_error;

endmodule
